// File: rtl/aap_pkg.sv
// Shared definitions for the 16-bit pipelined processor: redirect encodings,
// default widths and the fetch-stage state type.
package aap_pkg;

  localparam int PC_W    = 20;
  localparam int INSTR_W = 16;

  localparam logic [2:0] JUMP_NONE = 3'd0;
  localparam logic [2:0] JUMP_REL  = 3'd1;
  localparam logic [2:0] JUMP_ABS  = 3'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {instruction, pc} entries between fetch and decode.
// Synchronous clear empties it in one cycle; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding request/ack memory port, redirect
// handling with stale-response dropping, and a prefetch FIFO in front of decode.
module fetch_unit
  import aap_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W,
  parameter int INSTR_WIDTH = INSTR_W,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             pcjumpenable,
  input  logic [8:0]             pcchange,
  input  logic [PC_WIDTH-1:0]    pclocation,
  output logic [PC_WIDTH-1:0]    previous_programcounter,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   decode_ready
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = INSTR_WIDTH + PC_WIDTH;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;

  logic                redirect, ack, push, pop, room;
  logic [PC_WIDTH-1:0] target;
  logic [CNT_W-1:0]    fifo_count, count_next;
  logic                head_valid;
  logic [ENTRY_W-1:0]  head_data;
  logic [PC_WIDTH-1:0] head_pc;

  assign head_pc = head_data[PC_WIDTH-1:0];

  always_comb begin
    redirect   = (pcjumpenable == JUMP_REL) || (pcjumpenable == JUMP_ABS);
    target     = (pcjumpenable == JUMP_REL)
                 ? issue_pc_q + {{(PC_WIDTH-9){pcchange[8]}}, pcchange}
                 : pclocation;
    ack        = req_q && imem_ack;
    push       = ack && (state_q == ST_RUN) && !redirect;
    pop        = head_valid && decode_ready && !redirect;
    count_next = redirect ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    // A new request reserves the slot its data will land in.
    room       = (count_next < CNT_W'(BUF_DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    issue_pc_d = pop ? head_pc : issue_pc_q;

    if (redirect) begin
      fetch_pc_d = target;
      if (req_q && !imem_ack) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_RUN;
        req_d   = 1'b1;
        addr_d  = target;
      end
    end else if (state_q == ST_DROP) begin
      if (ack) begin
        state_d = ST_RUN;
        req_d   = room;
        addr_d  = fetch_pc_q;
      end
    end else if (!req_q || ack) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(push);
      req_d      = room;
      addr_d     = fetch_pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= '0;
      issue_pc_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (redirect),
    .push       (push),
    .push_data  ({imem_data, fetch_pc_q}),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign imem_req                = req_q;
  assign imem_addr               = addr_q;
  assign instr_valid             = head_valid;
  assign instr_out               = head_valid ? head_data[ENTRY_W-1:PC_WIDTH] : '0;
  assign instr_pc                = head_valid ? head_pc : '0;
  assign previous_programcounter = issue_pc_q + PC_WIDTH'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory (data = address)
// and a queue of expected fetch addresses compared on every pop to decode.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pcjumpenable = 3'd0;
  logic [8:0]  pcchange = 9'd0;
  logic [19:0] pclocation = 20'd0;
  logic [19:0] previous_programcounter;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'd0;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [19:0] instr_pc;
  logic        decode_ready = 1'b0;

  fetch_unit dut (
    .clock                   (clock),
    .reset                   (reset),
    .pcjumpenable            (pcjumpenable),
    .pcchange                (pcchange),
    .pclocation              (pclocation),
    .previous_programcounter (previous_programcounter),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ack                (imem_ack),
    .imem_data               (imem_data),
    .instr_valid             (instr_valid),
    .instr_out               (instr_out),
    .instr_pc                (instr_pc),
    .decode_ready            (decode_ready)
  );

  always #5 clock = ~clock;

  int          n_asserts = 0;
  int          n_fails   = 0;
  logic [19:0] sb[$];
  logic [19:0] exp_issue = 20'd0;
  bit          check_prev = 1'b0;
  int          mem_latency = 0;
  int          wait_cnt = 0;
  bit          force_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load_sb(input logic [19:0] start);
    logic [19:0] a;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      a = start + 20'(i);
      sb.push_back(a);
    end
  endtask

  // One clock cycle: memory response, scoreboard check on pop, advance to next negedge.
  task automatic cycle();
    bit          redir;
    logic [19:0] e;
    logic [19:0] link;
    redir    = (pcjumpenable == 3'd1) || (pcjumpenable == 3'd2);
    imem_ack  = 1'b0;
    imem_data = 16'd0;
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = 16'hDEAD;
      force_ack = 1'b0;
    end else if (imem_req === 1'b1) begin
      if (wait_cnt >= mem_latency) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr[15:0];
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (!reset && !redir && instr_valid === 1'b1 && decode_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_pc", 32'(instr_pc), 32'(e));
        chk("pop_instr", 32'(instr_out), 32'(e[15:0]));
        $display("pop pc=%05h instr=%04h expected_pc=%05h", instr_pc, instr_out, e);
        exp_issue = e;
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (check_prev && !reset) begin
      link = exp_issue + 20'd1;
      chk("prev_pc", 32'(previous_programcounter), 32'(link));
    end
  endtask

  task automatic wait_issue(input logic [19:0] tgt, input int limit, input string tag);
    int g = 0;
    while (exp_issue !== tgt && g < limit) begin
      cycle();
      g++;
    end
    chk(tag, 32'(exp_issue), 32'(tgt));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_out"},   32'(instr_out), 32'd0);
    chk({tag, "_pc"},    32'(instr_pc), 32'd0);
    chk({tag, "_prev"},  32'(previous_programcounter), 32'd1);
  endtask

  initial begin
    int g;
    @(negedge clock);
    reset = 1'b1;
    cycle();
    cycle();
    check_reset_outputs("rst");

    // Sequential fetch with zero-wait memory.
    exp_issue    = 20'd0;
    check_prev   = 1'b1;
    load_sb(20'd0);
    decode_ready = 1'b1;
    reset        = 1'b0;
    cycle();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    g = 0;
    while (instr_valid !== 1'b1 && g < 5) begin
      cycle();
      g++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc", 32'(instr_pc), 32'(k));
      cycle();
    end

    // Decode stall: FIFO fills, request gated off, order preserved afterwards.
    decode_ready = 1'b0;
    repeat (4) cycle();
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_count", 32'(dut.fifo_count), 32'd2);
    decode_ready = 1'b1;
    wait_issue(20'd10, 40, "reach_issue10");

    // Relative redirect: 10 + (-4) = 6.
    pcjumpenable = 3'd1;
    pcchange     = 9'h1FC;
    load_sb(20'd6);
    cycle();
    pcjumpenable = 3'd0;
    pcchange     = 9'd0;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", 32'(imem_addr), 32'd6);
    chk("rel_flush", 32'(instr_valid), 32'd0);
    cycle();
    chk("rel_valid", 32'(instr_valid), 32'd1);
    chk("rel_pc", 32'(instr_pc), 32'd6);
    repeat (3) cycle();

    // Encodings 3 and 7 are not redirects.
    pcjumpenable = 3'd3;
    pclocation   = 20'h00777;
    pcchange     = 9'h0AB;
    cycle();
    pcjumpenable = 3'd7;
    cycle();
    pcjumpenable = 3'd0;
    pclocation   = 20'd0;
    pcchange     = 9'd0;
    chk("rsv_valid", 32'(instr_valid), 32'd1);
    repeat (4) cycle();

    // Absolute redirect while the request at 5 is still waiting for its ack.
    decode_ready = 1'b0;
    repeat (4) cycle();
    chk("pre_abs_req", 32'(imem_req), 32'd0);
    mem_latency  = 3;
    decode_ready = 1'b1;
    pcjumpenable = 3'd2;
    pclocation   = 20'h00005;
    sb.delete();
    cycle();
    pcjumpenable = 3'd0;
    chk("abs5_req", 32'(imem_req), 32'd1);
    chk("abs5_addr", 32'(imem_addr), 32'h5);
    cycle();
    pcjumpenable = 3'd2;
    pclocation   = 20'h00100;
    load_sb(20'h00100);
    cycle();
    pcjumpenable = 3'd0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", 32'(imem_addr), 32'h5);
    g = 0;
    while (imem_addr === 20'h00005 && g < 10) begin
      cycle();
      g++;
    end
    chk("drop_next_addr", 32'(imem_addr), 32'h100);
    wait_issue(20'h00102, 40, "abs_stream");

    // Reset with an outstanding request and a simultaneous redirect, then a late ack.
    mem_latency = 20;
    repeat (2) cycle();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    reset        = 1'b1;
    pcjumpenable = 3'd2;
    pclocation   = 20'h00300;
    exp_issue    = 20'd0;
    sb.delete();
    cycle();
    reset        = 1'b0;
    pcjumpenable = 3'd0;
    check_reset_outputs("rst2");
    mem_latency = 0;
    force_ack   = 1'b1;
    load_sb(20'd0);
    cycle();
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);
    wait_issue(20'd3, 20, "restart_stream");

    // PC wrap across 2^20.
    pcjumpenable = 3'd2;
    pclocation   = 20'hFFFFE;
    load_sb(20'hFFFFE);
    cycle();
    pcjumpenable = 3'd0;
    pclocation   = 20'd0;
    wait_issue(20'd1, 20, "wrap_stream");
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
